// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the reset value of the instruction register and the PC increment.
package rv32i_fetch_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DROP  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/insn_fetch_unit.sv
// Fetch stage: single outstanding word read to instruction memory, an
// instruction register handed to decode, redirect handling and fault flag.
module insn_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned_fault
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  insn_reg, insn_next;
  logic [31:0]  insn_pc_reg, insn_pc_next;
  logic         insn_valid_reg, insn_valid_next;
  logic         fault_reg, fault_next;
  logic         drop_to_fault_reg, drop_to_fault_next;

  logic req_accept;
  logic rsp_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_REQ;
      pc_reg            <= RESET_VECTOR;
      insn_reg          <= INSN_NOP;
      insn_pc_reg       <= 32'h0000_0000;
      insn_valid_reg    <= 1'b0;
      fault_reg         <= 1'b0;
      drop_to_fault_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      insn_reg          <= insn_next;
      insn_pc_reg       <= insn_pc_next;
      insn_valid_reg    <= insn_valid_next;
      fault_reg         <= fault_next;
      drop_to_fault_reg <= drop_to_fault_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    insn_next          = insn_reg;
    insn_pc_next       = insn_pc_reg;
    insn_valid_next    = insn_valid_reg;
    fault_next         = fault_reg;
    drop_to_fault_next = drop_to_fault_reg;

    req_accept = (state_reg == ST_REQ) && imem_req_ready;
    // A response is still owed after this edge if a request is accepted now,
    // or one is outstanding and its data does not arrive this cycle.
    rsp_pending = req_accept ||
                  (((state_reg == ST_WAIT) || (state_reg == ST_DROP)) && !imem_rsp_valid);

    if (redirect_valid) begin
      pc_next            = redirect_pc;
      insn_valid_next    = 1'b0;
      fault_next         = !is_aligned(redirect_pc);
      drop_to_fault_next = !is_aligned(redirect_pc);
      if (rsp_pending) begin
        state_next = ST_DROP;
      end else if (!is_aligned(redirect_pc)) begin
        state_next = ST_FAULT;
      end else begin
        state_next = ST_REQ;
      end
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            insn_next       = imem_rsp_data;
            insn_pc_next    = pc_reg;
            insn_valid_next = 1'b1;
            state_next      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (insn_ready) begin
            pc_next         = pc_reg + PC_STEP;
            insn_valid_next = 1'b0;
            state_next      = ST_REQ;
          end
        end
        ST_DROP: begin
          // Stale word is discarded; a pending misaligned target parks in FAULT.
          if (imem_rsp_valid) begin
            state_next         = drop_to_fault_reg ? ST_FAULT : ST_REQ;
            drop_to_fault_next = 1'b0;
          end
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          state_next = ST_REQ;
        end
      endcase
    end
  end

  assign imem_req_valid   = rst_n && (state_reg == ST_REQ);
  assign imem_addr        = pc_reg;
  assign insn_valid       = insn_valid_reg;
  assign insn             = insn_reg;
  assign insn_pc          = insn_pc_reg;
  assign misaligned_fault = fault_reg;

endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
Fetch stage directly upstream of the instruction decoders (R/I/S/B/U/J). Holds the PC and issues one word read at a time to instruction memory over a valid/ready request channel. Latches the returned word into an instruction register and presents it, with its PC, to decode over a valid/ready handshake. Accepts redirects from branch/jump resolution, discards stale fetches, and flags misaligned targets.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  synchronous reset, active-low
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  request address (= pc)
imem_rsp_valid  in  1  read data valid, one pulse per accepted request
imem_rsp_data  in  32  read data
insn_valid  out  1  insn/insn_pc valid for decode
insn_ready  in  1  decode consumes insn
insn  out  32  instruction word to decoders
insn_pc  out  32  address of insn
redirect_valid  in  1  branch/jump taken, single-cycle pulse
redirect_pc  in  32  redirect target
misaligned_fault  out  1  sticky: redirect target not 4-byte aligned

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_VECTOR, state=REQ, insn=32'h0000_0013 (NOP), insn_pc=0, insn_valid=0, misaligned_fault=0. imem_req_valid is 0 while rst_n=0.
- At most one outstanding memory request. imem_rsp_valid arrives no earlier than the cycle after acceptance.
- States REQ, WAIT, HOLD, DROP, FAULT:
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready=1, go to WAIT.
- WAIT: on imem_rsp_valid=1, insn<=imem_rsp_data, insn_pc<=pc, insn_valid<=1, go to HOLD.
- HOLD: insn_valid=1. On insn_ready=1, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), insn_valid<=0, go to REQ. Next request issues the cycle after the handshake.
- DROP: wait for the stale imem_rsp_valid, discard it, then go to REQ.
- FAULT: imem_req_valid=0, insn_valid=0. Leave only on an aligned redirect or reset.
- Best-case throughput: one instruction every 3 cycles with zero-wait memory (REQ, WAIT, HOLD).
- Outputs insn, insn_pc and insn_valid are registered. insn and insn_pc hold their value while insn_valid=0.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle. Aligned target: pc<=redirect_pc, and:
- REQ without acceptance: stay in REQ. The address changes next cycle; this is the only permitted change of imem_addr while valid.
- REQ with acceptance that same cycle: go to DROP.
- WAIT without rsp: go to DROP.
- WAIT with rsp the same cycle: discard rsp, go to REQ.
- HOLD: insn_valid<=0 (even if insn_ready=1; that handshake does not count), go to REQ.
- DROP: stay in DROP and keep waiting for the stale response. If rsp arrives the same cycle, go to REQ.
- FAULT: go to REQ, misaligned_fault<=0.
- Misaligned redirect (redirect_pc[1:0]!=0): misaligned_fault<=1, insn_valid<=0, pc<=redirect_pc. Go to FAULT, except from REQ-accepted or WAIT, which go to DROP first and then to FAULT instead of REQ.
- Reset mid-operation: any in-flight response is ignored. Memory is required to drop outstanding requests on reset.
- imem_rsp_valid in REQ, HOLD or FAULT is a protocol violation. Ignore it; the bench asserts it never occurs.

Decomposition:
- Shared package rv32i_fetch_pkg holds the state enum encoding (REQ, WAIT, HOLD, DROP, FAULT) and the constants INSN_NOP=32'h0000_0013 and PC_STEP=4.
- No sub-module: a single module with a pc register, an instruction register and a 5-state FSM.
- ClockGen is reused in the testbench only.

Test Plan:
- Reset, zero-wait memory returning 32'h00F100B3 at 0x0 and 32'h402A00B3 at 0x4, insn_ready=1 → insn_valid pulses with (insn_pc=0x0, insn=00F100B3), then (0x4, 402A00B3). Requests come 3 cycles apart, first imem_addr=0x0.
- Backpressure: insn_ready=0 for 5 cycles in HOLD → insn/insn_pc stable, imem_req_valid=0, no pc advance. Release → next imem_addr=0x4.
- Redirect to 0x100 in WAIT, with the stale rsp 2 cycles later → stale word never reaches insn_valid, next imem_addr=0x100.
- Redirect to 0x200 in HOLD with insn_ready=1 the same cycle → no handshake counted, insn_valid=0 next cycle, next imem_addr=0x200.
- Redirect to 0x102 → misaligned_fault=1, imem_req_valid=0, insn_valid=0. Then redirect to 0x300 → fault clears, imem_addr=0x300.
- rst_n=0 while in WAIT, then rsp arrives → outputs at reset values, fetch restarts at RESET_VECTOR. Also check PC wrap 0xFFFF_FFFC → 0x0.
